// File: rtl/writeback_queue.sv
// Writeback buffer ahead of the register file: queues up to two results per cycle
// in order and drains up to two per cycle onto the two write ports.
module writeback_queue #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in0_valid,
  input  logic [ADDR_WIDTH-1:0]         in0_reg,
  input  logic [DATA_WIDTH-1:0]         in0_data,
  input  logic                          in1_valid,
  input  logic [ADDR_WIDTH-1:0]         in1_reg,
  input  logic [DATA_WIDTH-1:0]         in1_data,
  output logic                          in_ready,
  output logic [ADDR_WIDTH-1:0]         wr1,
  output logic [DATA_WIDTH-1:0]         wr1_data,
  output logic                          wr1_enable,
  output logic [ADDR_WIDTH-1:0]         wr2,
  output logic [DATA_WIDTH-1:0]         wr2_data,
  output logic                          wr2_enable,
  output logic [(1<<ADDR_WIDTH)-1:0]    pending,
  output logic [$clog2(DEPTH):0]        count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] mem_reg  [DEPTH];
  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [PTR_W-1:0]      head1;
  logic [PTR_W-1:0]      tail1;
  logic [1:0]            push_n;
  logic [1:0]            pop_n;
  logic                  same_reg;

  // Space check uses only the pre-edge count, never this cycle's pop.
  assign in_ready = !reset && ((CNT_W'(DEPTH) - count) >= CNT_W'(2));

  always_comb begin
    head1    = head + PTR_W'(1);
    tail1    = tail + PTR_W'(1);
    push_n   = 2'd0;
    if (in_ready) begin
      push_n = {1'b0, in0_valid} + {1'b0, in1_valid};
    end
    if (count == CNT_W'(0)) begin
      pop_n = 2'd0;
    end else if (count == CNT_W'(1)) begin
      pop_n = 2'd1;
    end else begin
      pop_n = 2'd2;
    end
    same_reg = (mem_reg[head] == mem_reg[head1]);
  end

  // Entry storage; occupancy is tracked by count, so no reset is needed here.
  always_ff @(posedge clock) begin
    if (in_ready) begin
      if (in0_valid) begin
        mem_reg[tail]  <= in0_reg;
        mem_data[tail] <= in0_data;
      end
      if (in1_valid) begin
        mem_reg[in0_valid ? tail1 : tail]  <= in1_reg;
        mem_data[in0_valid ? tail1 : tail] <= in1_data;
      end
    end
  end

  // Pointers, occupancy and the registered write-port stage.
  always_ff @(posedge clock) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      wr1        <= '0;
      wr1_data   <= '0;
      wr1_enable <= 1'b0;
      wr2        <= '0;
      wr2_data   <= '0;
      wr2_enable <= 1'b0;
    end else begin
      wr1        <= '0;
      wr1_data   <= '0;
      wr1_enable <= 1'b0;
      wr2        <= '0;
      wr2_data   <= '0;
      wr2_enable <= 1'b0;
      if (pop_n == 2'd1) begin
        wr1        <= mem_reg[head];
        wr1_data   <= mem_data[head];
        wr1_enable <= 1'b1;
      end else if (pop_n == 2'd2) begin
        // Same destination: the younger result alone is written.
        wr2        <= mem_reg[head1];
        wr2_data   <= mem_data[head1];
        wr2_enable <= 1'b1;
        if (!same_reg) begin
          wr1        <= mem_reg[head];
          wr1_data   <= mem_data[head];
          wr1_enable <= 1'b1;
        end
      end
      head  <= head + PTR_W'(pop_n);
      tail  <= tail + PTR_W'(push_n);
      count <= count + CNT_W'(push_n) - CNT_W'(pop_n);
    end
  end

  // Hazard mask over queued entries and the staged write ports.
  always_comb begin
    pending = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count) begin
        pending[mem_reg[head + PTR_W'(i)]] = 1'b1;
      end
    end
    if (wr1_enable) pending[wr1] = 1'b1;
    if (wr2_enable) pending[wr2] = 1'b1;
  end

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: directed vector table, reset corner cases and
// randomized traffic against a queue-based reference model with a regfile copy.
module tb_writeback_queue;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [1:0]  r;
    logic [15:0] d;
  } ent_t;

  typedef struct {
    logic v0; logic [1:0] r0; logic [15:0] d0;
    logic v1; logic [1:0] r1; logic [15:0] d1;
    logic e1; logic [1:0] a1; logic [15:0] x1;
    logic e2; logic [1:0] a2; logic [15:0] x2;
    logic [2:0] cnt; logic [3:0] pend;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        in0_valid, in1_valid;
  logic [1:0]  in0_reg, in1_reg;
  logic [15:0] in0_data, in1_data;
  logic        in_ready;
  logic [1:0]  wr1, wr2;
  logic [15:0] wr1_data, wr2_data;
  logic        wr1_enable, wr2_enable;
  logic [3:0]  pending;
  logic [2:0]  count;

  int passed = 0;
  int total  = 0;

  // Regfile fed by the DUT write ports.
  logic [15:0] dreg [4] = '{default: 16'h0};
  int          nwrites = 0;

  // Reference model state.
  ent_t        mq[$];
  logic        m1_en = 1'b0, m2_en = 1'b0;
  logic [1:0]  m1_reg = 2'd0, m2_reg = 2'd0;
  logic [15:0] m1_data = 16'h0, m2_data = 16'h0;
  logic [15:0] mreg [4] = '{default: 16'h0};

  vec_t vt[9];

  writeback_queue dut (
    .clock(clock), .reset(reset),
    .in0_valid(in0_valid), .in0_reg(in0_reg), .in0_data(in0_data),
    .in1_valid(in1_valid), .in1_reg(in1_reg), .in1_data(in1_data),
    .in_ready(in_ready),
    .wr1(wr1), .wr1_data(wr1_data), .wr1_enable(wr1_enable),
    .wr2(wr2), .wr2_data(wr2_data), .wr2_enable(wr2_enable),
    .pending(pending), .count(count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (wr1_enable) dreg[wr1] <= wr1_data;
    if (wr2_enable) dreg[wr2] <= wr2_data;
    nwrites <= nwrites + int'(wr1_enable) + int'(wr2_enable);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input logic v0, input logic [1:0] r0, input logic [15:0] d0,
                       input logic v1, input logic [1:0] r1, input logic [15:0] d1);
    in0_valid = v0; in0_reg = r0; in0_data = d0;
    in1_valid = v1; in1_reg = r1; in1_data = d1;
  endtask

  // One clock edge of the reference: commit staged writes, pop, then push.
  task automatic model_step();
    ent_t a, b;
    int   n;
    if (m1_en) mreg[m1_reg] = m1_data;
    if (m2_en) mreg[m2_reg] = m2_data;
    m1_en = 1'b0;
    m2_en = 1'b0;
    if (reset) begin
      mq.delete();
    end else begin
      n = mq.size();
      if (n == 1) begin
        a = mq.pop_front();
        m1_en = 1'b1; m1_reg = a.r; m1_data = a.d;
      end else if (n >= 2) begin
        a = mq.pop_front();
        b = mq.pop_front();
        m2_en = 1'b1; m2_reg = b.r; m2_data = b.d;
        if (a.r != b.r) begin
          m1_en = 1'b1; m1_reg = a.r; m1_data = a.d;
        end
      end
      if (n <= DEPTH - 2) begin
        if (in0_valid) mq.push_back(ent_t'({in0_reg, in0_data}));
        if (in1_valid) mq.push_back(ent_t'({in1_reg, in1_data}));
      end
    end
  endtask

  task automatic model_compare();
    logic [3:0] ep;
    ep = 4'b0;
    foreach (mq[i]) ep[mq[i].r] = 1'b1;
    if (m1_en) ep[m1_reg] = 1'b1;
    if (m2_en) ep[m2_reg] = 1'b1;
    check("wr1_enable", 32'(wr1_enable), 32'(m1_en));
    check("wr2_enable", 32'(wr2_enable), 32'(m2_en));
    if (m1_en) begin
      check("wr1", 32'(wr1), 32'(m1_reg));
      check("wr1_data", 32'(wr1_data), 32'(m1_data));
    end
    if (m2_en) begin
      check("wr2", 32'(wr2), 32'(m2_reg));
      check("wr2_data", 32'(wr2_data), 32'(m2_data));
    end
    check("count", 32'(count), 32'(mq.size()));
    check("pending", 32'(pending), 32'(ep));
    check("in_ready", 32'(in_ready), 32'(!reset && (mq.size() <= DEPTH - 2)));
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    model_compare();
  endtask

  initial begin
    logic [1:0]  ra, rb;
    logic [15:0] snap [4];
    int          w0;

    // Directed vectors: inputs for one edge, expected outputs after it.
    vt[0] = '{1'b1, 2'd1, 16'h0010, 1'b1, 2'd3, 16'h0020, 1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 16'h0, 3'd2, 4'b1010};
    vt[1] = '{1'b0, 2'd0, 16'h0,    1'b0, 2'd0, 16'h0,    1'b1, 2'd1, 16'h0010, 1'b1, 2'd3, 16'h0020, 3'd0, 4'b1010};
    vt[2] = '{1'b0, 2'd0, 16'h0,    1'b0, 2'd0, 16'h0,    1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 16'h0, 3'd0, 4'b0000};
    vt[3] = '{1'b1, 2'd2, 16'h1111, 1'b1, 2'd2, 16'hABCD, 1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 16'h0, 3'd2, 4'b0100};
    vt[4] = '{1'b0, 2'd0, 16'h0,    1'b0, 2'd0, 16'h0,    1'b0, 2'd0, 16'h0, 1'b1, 2'd2, 16'hABCD, 3'd0, 4'b0100};
    vt[5] = '{1'b0, 2'd0, 16'h0,    1'b0, 2'd0, 16'h0,    1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 16'h0, 3'd0, 4'b0000};
    vt[6] = '{1'b0, 2'd3, 16'hDEAD, 1'b1, 2'd0, 16'h00FF, 1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 16'h0, 3'd1, 4'b0001};
    vt[7] = '{1'b0, 2'd0, 16'h0,    1'b0, 2'd0, 16'h0,    1'b1, 2'd0, 16'h00FF, 1'b0, 2'd0, 16'h0, 3'd0, 4'b0001};
    vt[8] = '{1'b0, 2'd0, 16'h0,    1'b0, 2'd0, 16'h0,    1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 16'h0, 3'd0, 4'b0000};

    reset = 1'b1;
    drive(1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 16'h0);
    #1;
    for (int i = 0; i < 10; i++) tick();

    reset = 1'b0;
    #1;
    check("rst_wr1", 32'(wr1), 32'd0);
    check("rst_wr1_data", 32'(wr1_data), 32'd0);
    check("rst_wr1_enable", 32'(wr1_enable), 32'd0);
    check("rst_wr2", 32'(wr2), 32'd0);
    check("rst_wr2_data", 32'(wr2_data), 32'd0);
    check("rst_wr2_enable", 32'(wr2_enable), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);

    for (int i = 0; i < 9; i++) begin
      drive(vt[i].v0, vt[i].r0, vt[i].d0, vt[i].v1, vt[i].r1, vt[i].d1);
      tick();
      check($sformatf("vec%0d_wr1_enable", i), 32'(wr1_enable), 32'(vt[i].e1));
      check($sformatf("vec%0d_wr2_enable", i), 32'(wr2_enable), 32'(vt[i].e2));
      if (vt[i].e1) check($sformatf("vec%0d_wr1", i), 32'({wr1, wr1_data}), 32'({vt[i].a1, vt[i].x1}));
      if (vt[i].e2) check($sformatf("vec%0d_wr2", i), 32'({wr2, wr2_data}), 32'({vt[i].a2, vt[i].x2}));
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vt[i].cnt));
      check($sformatf("vec%0d_pending", i), 32'(pending), 32'(vt[i].pend));
    end
    check("reg_r1", 32'(dreg[1]), 32'h0010);
    check("reg_r3", 32'(dreg[3]), 32'h0020);
    check("reg_r2", 32'(dreg[2]), 32'hABCD);
    check("reg_r0", 32'(dreg[0]), 32'h00FF);

    // Back-to-back distinct-register pairs: 16 writes, no stall.
    w0 = nwrites;
    for (int i = 0; i < 8; i++) begin
      ra = 2'($urandom_range(0, 3));
      rb = ra ^ 2'($urandom_range(1, 3));
      drive(1'b1, ra, 16'($urandom), 1'b1, rb, 16'($urandom));
      tick();
      check("b2b_count_le2", 32'(count <= 3'd2), 32'd1);
      check("b2b_in_ready", 32'(in_ready), 32'd1);
    end
    drive(1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 16'h0);
    for (int i = 0; i < 3; i++) tick();
    check("b2b_writes", 32'(nwrites - w0), 32'd16);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 39) == 0);
      drive(1'($urandom), 2'($urandom), 16'($urandom), 1'($urandom), 2'($urandom), 16'($urandom));
      tick();
    end
    reset = 1'b0;
    drive(1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 16'h0);
    for (int i = 0; i < 3; i++) tick();

    // Reset with one pair staged and another queued: the queued pair is lost.
    drive(1'b1, 2'd0, 16'h1234, 1'b1, 2'd1, 16'h5678);
    tick();
    snap[2] = mreg[2];
    snap[3] = mreg[3];
    drive(1'b1, 2'd2, 16'h9999, 1'b1, 2'd3, 16'h7777);
    tick();
    drive(1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 16'h0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_enables", 32'({wr1_enable, wr2_enable}), 32'd0);
      check("post_rst_pending", 32'(pending), 32'd0);
    end
    check("post_rst_r2", 32'(dreg[2]), 32'(snap[2]));
    check("post_rst_r3", 32'(dreg[3]), 32'(snap[3]));
    check("post_rst_r0", 32'(dreg[0]), 32'h1234);
    check("post_rst_r1", 32'(dreg[1]), 32'h5678);

    for (int r = 0; r < 4; r++) check($sformatf("final_reg%0d", r), 32'(dreg[r]), 32'(mreg[r]));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
